// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - LSB-first serial-to-parallel deserializer with one-word output buffer
// Optional even-parity bit per word when PISO_PARITY_CHECK_EN is defined.
module sipo_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             si,
  input  logic             si_valid,
  input  logic             si_first,
  output logic [WIDTH-1:0] po,
  output logic             po_valid,
  input  logic             po_ready,
  input  logic             clr_ovf,
  output logic             overflow,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_DATA = 2'd1,
    RX_PAR  = 2'd2
  } rx_state_t;

  rx_state_t        r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_po;
  logic             r_po_valid;
  logic             r_ovf;

  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_word;
  logic             w_done;
  logic             w_free;
  logic             w_last_data;

  assign w_shift     = {si, r_shreg[WIDTH-1:1]};
  assign w_free      = !r_po_valid || po_ready;
  assign w_last_data = (r_state == RX_DATA) && (r_cnt == CW'(WIDTH - 1));

`ifdef PISO_PARITY_CHECK_EN
  logic r_perr;
  logic w_perr;

  // In RX_PAR the shift register already holds the whole word; si is the parity bit.
  always_comb begin
    w_done = 1'b0;
    w_perr = 1'b0;
    w_word = r_shreg;
    if (si_valid && !si_first && (r_state == RX_PAR)) begin
      if (si == ^r_shreg) w_done = 1'b1;
      else                w_perr = 1'b1;
    end
  end

  assign parity_err = r_perr;
`else
  always_comb begin
    w_word = w_shift;
    w_done = si_valid && !si_first && w_last_data;
  end

  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= RX_IDLE;
      r_cnt      <= '0;
      r_shreg    <= '0;
      r_po       <= '0;
      r_po_valid <= 1'b0;
      r_ovf      <= 1'b0;
`ifdef PISO_PARITY_CHECK_EN
      r_perr     <= 1'b0;
`endif
    end else begin
`ifdef PISO_PARITY_CHECK_EN
      r_perr <= w_perr;
`endif
      if (si_valid) begin
        if (si_first || (r_state == RX_IDLE)) begin
          r_shreg <= w_shift;
          r_cnt   <= CW'(1);
          r_state <= RX_DATA;
`ifdef PISO_PARITY_CHECK_EN
        end else if (r_state == RX_PAR) begin
          r_cnt   <= '0;
          r_state <= RX_IDLE;
`endif
        end else if (w_last_data) begin
          r_shreg <= w_shift;
`ifdef PISO_PARITY_CHECK_EN
          r_cnt   <= CW'(WIDTH);
          r_state <= RX_PAR;
`else
          r_cnt   <= '0;
          r_state <= RX_IDLE;
`endif
        end else begin
          r_shreg <= w_shift;
          r_cnt   <= r_cnt + CW'(1);
        end
      end

      // Output buffer: a handshake on the completing edge frees the slot for the new word.
      if (w_done && w_free) begin
        r_po       <= w_word;
        r_po_valid <= 1'b1;
      end else if (r_po_valid && po_ready) begin
        r_po_valid <= 1'b0;
      end

      if (w_done && !w_free) r_ovf <= 1'b1;
      else if (clr_ovf)      r_ovf <= 1'b0;
    end
  end

  assign po       = r_po;
  assign po_valid = r_po_valid;
  assign overflow = r_ovf;

endmodule
